hpdcache_wbuf_sched: RTL and testbench
======================================

// Module: hpdcache_wbuf_sched
// PURPOSE
//  Write-buffer entry scheduler for the HPDcache WBUF directory. Tracks the lifecycle of every
//  directory entry (FREE->OPEN->PEND->SENT->FREE), runs per-entry coalescing timers and decides
//  when and in which order entries are sent to memory. Sits between the WBUF directory/data
//  storage (datapath, not in this block) and the memory write-request interface.
// PARAMETERS
//  DIR_ENTRIES    16  number of WBUF directory entries (>=2)
//  TIMECNT_WIDTH  4   width of each per-entry coalescing timer
//  IDX_W          $clog2(DIR_ENTRIES)  derived, entry index width (localparam)
// PORTS
//  clk_i          in   1              clock
//  rst_ni         in   1              async active-low reset
//  cfg_thresh_i   in   TIMECNT_WIDTH  timeout threshold; 0 = entry goes PEND one cycle after alloc
//  alloc_i        in   1              request to open a new entry
//  alloc_ready_o  out  1              a FREE entry exists
//  alloc_idx_o    out  IDX_W          lowest-index FREE entry (valid when alloc_ready_o)
//  write_i        in   1              coalescing write hit on an OPEN entry
//  write_idx_i    in   IDX_W          entry written
//  flush_all_i    in   1              force every OPEN entry to PEND
//  send_valid_o   out  1              a PEND entry is offered to memory
//  send_ready_i   in   1              memory accepts the offered entry
//  send_idx_o     out  IDX_W          offered entry
//  ack_i          in   1              memory write acknowledge
//  ack_idx_i      in   IDX_W          acknowledged entry
//  empty_o        out  1              all entries FREE
//  full_o         out  1              no entry FREE
// BEHAVIOUR
//  - Reset: all entries FREE, timers 0, RR pointer 0; so alloc_ready_o=1, alloc_idx_o=0,
//    send_valid_o=0, send_idx_o=0, empty_o=1, full_o=0.
//  - State per entry (2b). All transitions take effect at the next rising edge; decisions use
//    the current-cycle state only (no same-cycle bypass).
//  - FREE->OPEN: alloc_i && alloc_ready_o; entry alloc_idx_o, timer cleared to 0.
//  - OPEN: timer increments by 1 per cycle, saturating at all-ones.
//    OPEN->PEND when timer >= cfg_thresh_i, or flush_all_i.
//    write_i on the entry clears timer to 0 and suppresses the timeout in that cycle;
//    flush_all_i has priority over write_i (entry -> PEND, write still coalesced by datapath).
//  - PEND->SENT: send handshake (send_valid_o && send_ready_i) on send_idx_o.
//  - SENT->FREE: ack_i on ack_idx_i. Ack of a non-SENT entry is ignored (assertion fires).
//    write_i on a non-OPEN entry is illegal (assertion); state unchanged.
//  - Send selection: round-robin over PEND entries starting at RR pointer, combinational from
//    registered state; on handshake pointer <= send_idx_o+1 (wraps DIR_ENTRIES-1 -> 0).
//    Once offered, send_idx_o is stable until handshake (PEND cannot be left otherwise).
//  - Timeout and alloc same cycle: newly allocated entry is not timed until next cycle.
//  - Ack and alloc same cycle: freed entry is allocatable only from the next cycle; full_o
//    reflects current state.
//  - Reset mid-operation: all state discarded asynchronously; in-flight SENT entries are lost
//    (top level guarantees memory side is reset too).
// TESTING
//  - Reset release: empty_o=1, alloc_idx_o=0, send_valid_o=0.
//  - cfg_thresh_i=3, alloc at t0, no writes -> entry 0 PEND at t0+4, send_valid_o=1, send_idx_o=0;
//    ready=1 -> SENT; ack(0) -> empty_o=1 next cycle.
//  - cfg_thresh_i=2, writes to entry 0 every cycle for 10 cycles -> never PEND; stop writes ->
//    PEND 3 cycles later.
//  - Fill 16 entries -> full_o=1, alloc_ready_o=0; flush_all_i -> 16 sends in order 0..15 with
//    ready=1; then ack all in reverse order -> empty_o=1.
//  - RR fairness: entries 2,5,9 PEND, pointer 6 -> send order 9,2,5.
//  - Same cycle write+flush_all on entry 1 -> PEND; ack to a PEND entry -> ignored, assertion hit.

Source files
------------

// File: rtl/hpdcache_wbuf_sched.sv
// -----------------------------------------------------------------------------
// hpdcache_wbuf_sched
//   Write-buffer entry scheduler for the HPDcache WBUF directory. Each directory
//   entry has a life-cycle FREE -> OPEN -> PEND -> SENT -> FREE. While an entry
//   is OPEN a coalescing timer runs. The entry is closed (PEND) on timeout or on
//   a global flush. PEND entries are offered to memory in round-robin order.
//   An acknowledge from memory releases a SENT entry.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   cfg_thresh_i           coalescing timeout threshold (0 = close next cycle)
//   alloc_i                open a new entry (lowest-index FREE one)
//   alloc_ready_o          some entry is FREE
//   alloc_idx_o            entry that alloc_i would open
//   write_i, write_idx_i   coalescing write hit on an OPEN entry (restarts timer)
//   flush_all_i            close every OPEN entry
//   send_valid_o           a PEND entry is offered to memory
//   send_ready_i           memory accepts the offered entry
//   send_idx_o             offered entry
//   ack_i, ack_idx_i       memory write acknowledge for a SENT entry
//   empty_o                every entry is FREE
//   full_o                 no entry is FREE
// -----------------------------------------------------------------------------
module hpdcache_wbuf_sched #(
  parameter int unsigned  DIR_ENTRIES   = 16,
  parameter int unsigned  TIMECNT_WIDTH = 4,
  localparam int unsigned IDX_W         = $clog2(DIR_ENTRIES)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [TIMECNT_WIDTH-1:0] cfg_thresh_i,
  input  logic                     alloc_i,
  output logic                     alloc_ready_o,
  output logic [IDX_W-1:0]         alloc_idx_o,
  input  logic                     write_i,
  input  logic [IDX_W-1:0]         write_idx_i,
  input  logic                     flush_all_i,
  output logic                     send_valid_o,
  input  logic                     send_ready_i,
  output logic [IDX_W-1:0]         send_idx_o,
  input  logic                     ack_i,
  input  logic [IDX_W-1:0]         ack_idx_i,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam logic [1:0] ST_FREE = 2'd0;
  localparam logic [1:0] ST_OPEN = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;
  localparam logic [1:0] ST_SENT = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIR_ENTRIES - 1);
  localparam logic [IDX_W:0]   N_WIDE   = (IDX_W+1)'(DIR_ENTRIES);

  // Per-entry state and coalescing timer
  logic [1:0]               state_q [DIR_ENTRIES];
  logic [1:0]               state_d [DIR_ENTRIES];
  logic [TIMECNT_WIDTH-1:0] timer_q [DIR_ENTRIES];
  logic [TIMECNT_WIDTH-1:0] timer_d [DIR_ENTRIES];

  // Round-robin pointer and offer lock
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

  logic             alloc_ready;
  logic [IDX_W-1:0] alloc_idx;
  logic             empty;
  logic             rr_found;
  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W:0]   rr_sum;
  logic             send_valid;
  logic [IDX_W-1:0] send_idx;
  logic             send_hs;

  // ---------------------------------------------------------------------------
  // Lowest-index FREE entry; scanning downwards leaves the lowest one in place.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default before any branch; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    alloc_ready = 1'b0;
    alloc_idx   = '0;
    empty       = 1'b1;
    for (int i = int'(DIR_ENTRIES) - 1; i >= 0; i--) begin
      if (state_q[i] == ST_FREE) begin
        alloc_ready = 1'b1;
        alloc_idx   = IDX_W'(i);
      end else begin
        empty = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin search for the first PEND entry at or after rr_ptr_q. The sum
  // is one bit wider so a single conditional subtract implements the wrap for
  // any entry count, not only powers of two.
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_sum   = '0;
    for (int k = 0; k < int'(DIR_ENTRIES); k++) begin
      rr_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (rr_sum >= N_WIDE) rr_sum = rr_sum - N_WIDE;
      if (!rr_found && state_q[rr_sum[IDX_W-1:0]] == ST_PEND) begin
        rr_found = 1'b1;
        rr_idx   = rr_sum[IDX_W-1:0];
      end
    end
  end

  // An entry offered without being taken stays locked as the offer, so a newly
  // closed entry nearer the pointer cannot displace it before the handshake.
  assign send_valid = lock_q | rr_found;
  assign send_idx   = lock_q ? lock_idx_q : rr_idx;
  assign send_hs    = send_valid & send_ready_i;

  // ---------------------------------------------------------------------------
  // Next state of every entry. Decisions use only the current registered
  // state, so an entry freed or opened this cycle is acted upon next cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < int'(DIR_ENTRIES); i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      unique case (state_q[i])
        ST_FREE: begin
          if (alloc_i && alloc_ready && alloc_idx == IDX_W'(i)) begin
            state_d[i] = ST_OPEN;
            timer_d[i] = '0;
          end
        end
        ST_OPEN: begin
          // Flush wins over a write hit; the datapath still merges the write.
          if (flush_all_i) begin
            state_d[i] = ST_PEND;
          end else if (write_i && write_idx_i == IDX_W'(i)) begin
            timer_d[i] = '0;
          end else if (timer_q[i] >= cfg_thresh_i) begin
            state_d[i] = ST_PEND;
          end else if (timer_q[i] != '1) begin
            timer_d[i] = timer_q[i] + 1'b1;
          end
        end
        ST_PEND: begin
          if (send_hs && send_idx == IDX_W'(i)) state_d[i] = ST_SENT;
        end
        default: begin // ST_SENT
          if (ack_i && ack_idx_i == IDX_W'(i)) state_d[i] = ST_FREE;
        end
      endcase
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (send_hs) begin
      rr_ptr_d = (send_idx == LAST_IDX) ? '0 : send_idx + 1'b1;
      lock_d   = 1'b0;
    end else if (send_valid) begin
      lock_d     = 1'b1;
      lock_idx_d = send_idx;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments so all
  // registers see pre-edge values. The per-entry arrays are small flop banks,
  // not RAM, so they are reset along with everything else.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DIR_ENTRIES); i++) begin
        state_q[i] <= ST_FREE;
        timer_q[i] <= '0;
      end
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      for (int i = 0; i < int'(DIR_ENTRIES); i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  assign alloc_ready_o = alloc_ready;
  assign alloc_idx_o   = alloc_idx;
  assign send_valid_o  = send_valid;
  assign send_idx_o    = send_idx;
  assign empty_o       = empty;
  assign full_o        = ~alloc_ready;

`ifndef SYNTHESIS
  // A write hit must target an OPEN entry; anything else is a directory bug.
  write_on_open: assert property (@(posedge clk_i) disable iff (!rst_ni)
    write_i |-> state_q[write_idx_i] == ST_OPEN)
    else $error("wbuf_sched: write to non-OPEN entry %0d", write_idx_i);

  // A stray acknowledge is dropped without touching the entry.
  ack_on_sent: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ack_i |-> state_q[ack_idx_i] == ST_SENT)
    else $warning("wbuf_sched: ack to non-SENT entry %0d ignored", ack_idx_i);
`endif

endmodule

// File: tb/tb_hpdcache_wbuf_sched.sv
// -----------------------------------------------------------------------------
// tb_hpdcache_wbuf_sched
//   Directed stimulus for the WBUF scheduler. A behavioural model of the entry
//   life-cycle runs alongside the DUT and every cycle's outputs are compared
//   against it; literal expectations at key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_hpdcache_wbuf_sched;

  localparam int N  = 16;
  localparam int TW = 4;
  localparam int IW = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [TW-1:0] cfg_thresh_i;
  logic          alloc_i;
  logic          alloc_ready_o;
  logic [IW-1:0] alloc_idx_o;
  logic          write_i;
  logic [IW-1:0] write_idx_i;
  logic          flush_all_i;
  logic          send_valid_o;
  logic          send_ready_i;
  logic [IW-1:0] send_idx_o;
  logic          ack_i;
  logic [IW-1:0] ack_idx_i;
  logic          empty_o;
  logic          full_o;

  hpdcache_wbuf_sched #(
    .DIR_ENTRIES  (N),
    .TIMECNT_WIDTH(TW)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cfg_thresh_i (cfg_thresh_i),
    .alloc_i      (alloc_i),
    .alloc_ready_o(alloc_ready_o),
    .alloc_idx_o  (alloc_idx_o),
    .write_i      (write_i),
    .write_idx_i  (write_idx_i),
    .flush_all_i  (flush_all_i),
    .send_valid_o (send_valid_o),
    .send_ready_i (send_ready_i),
    .send_idx_o   (send_idx_o),
    .ack_i        (ack_i),
    .ack_idx_i    (ack_idx_i),
    .empty_o      (empty_o),
    .full_o       (full_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: entry phases, age since open/last write, RR pointer and
  // the entry currently held on offer (-1 when none).
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {M_FREE, M_OPEN, M_PEND, M_SENT} m_st_e;

  m_st_e m_st  [N];
  int    m_age [N];
  int    m_ptr;
  int    m_held;

  function automatic int m_lowest_free();
    for (int i = 0; i < N; i++) if (m_st[i] == M_FREE) return i;
    return -1;
  endfunction

  function automatic int m_n_free();
    int n = 0;
    for (int i = 0; i < N; i++) if (m_st[i] == M_FREE) n++;
    return n;
  endfunction

  function automatic int m_offer();
    if (m_held >= 0) return m_held;
    for (int k = 0; k < N; k++) if (m_st[(m_ptr + k) % N] == M_PEND) return (m_ptr + k) % N;
    return -1;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin : model
    int a, o;
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) begin
        m_st[i]  <= M_FREE;
        m_age[i] <= 0;
      end
      m_ptr  <= 0;
      m_held <= -1;
    end else begin
      a = m_lowest_free();
      o = m_offer();
      for (int i = 0; i < N; i++) begin
        case (m_st[i])
          M_FREE: if (alloc_i && i == a) begin
            m_st[i]  <= M_OPEN;
            m_age[i] <= 0;
          end
          M_OPEN: begin
            if (flush_all_i) m_st[i] <= M_PEND;
            else if (write_i && int'(write_idx_i) == i) m_age[i] <= 0;
            else if (m_age[i] >= int'(cfg_thresh_i)) m_st[i] <= M_PEND;
            else if (m_age[i] < (1 << TW) - 1) m_age[i] <= m_age[i] + 1;
          end
          M_PEND: if (send_ready_i && i == o) m_st[i] <= M_SENT;
          default: if (ack_i && int'(ack_idx_i) == i) m_st[i] <= M_FREE;
        endcase
      end
      if (o >= 0 && send_ready_i) begin
        m_ptr  <= (o + 1) % N;
        m_held <= -1;
      end else begin
        m_held <= o;
      end
    end
  end

  // Every cycle out of reset, all outputs against the model (mid-cycle).
  always @(negedge clk_i) begin : compare
    int a, o;
    if (rst_ni === 1'b1) begin
      a = m_lowest_free();
      o = m_offer();
      check("alloc_ready", alloc_ready_o, a >= 0);
      if (a >= 0) check("alloc_idx", alloc_idx_o, a);
      check("send_valid", send_valid_o, o >= 0);
      if (o >= 0) check("send_idx", send_idx_o, o);
      check("empty", empty_o, m_n_free() == N);
      check("full", full_o, m_n_free() == 0);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 2 time units after the rising edge.
  // ---------------------------------------------------------------------------
  int sent_q[$];

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle_inputs();
    alloc_i      = 1'b0;
    write_i      = 1'b0;
    write_idx_i  = '0;
    flush_all_i  = 1'b0;
    send_ready_i = 1'b0;
    ack_i        = 1'b0;
    ack_idx_i    = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst_empty", empty_o, 1);
    check("rst_full", full_o, 0);
    check("rst_alloc_ready", alloc_ready_o, 1);
    check("rst_alloc_idx", alloc_idx_o, 0);
    check("rst_send_valid", send_valid_o, 0);
    check("rst_send_idx", send_idx_o, 0);
  endtask

  // Cycles until send_valid_o rises; returns bound on expiry.
  task automatic wait_valid(input int bound, output int n);
    n = 0;
    while (n < bound) begin
      @(negedge clk_i);
      if (send_valid_o) return;
      n++;
      tick();
    end
  endtask

  // Accept offers with ready high and record their order.
  task automatic collect_sends(input int want, input int bound);
    int cyc = 0;
    sent_q.delete();
    while (sent_q.size() < want && cyc < bound) begin
      @(negedge clk_i);
      if (send_valid_o) sent_q.push_back(int'(send_idx_o));
      send_ready_i = 1'b1;
      tick();
      cyc++;
    end
    send_ready_i = 1'b0;
  endtask

  task automatic ack_one(input int idx);
    ack_i     = 1'b1;
    ack_idx_i = IW'(idx);
    tick();
    ack_i     = 1'b0;
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    int exp_rr[3];
    rst_ni       = 1'b0;
    cfg_thresh_i = TW'(3);
    idle_inputs();

    // Threshold 3, single entry: closes 4 cycles after the allocating edge.
    do_reset();
    alloc_i = 1'b1;
    tick();
    alloc_i = 1'b0;
    wait_valid(20, n);
    check("t3_pend_latency", n, 4);
    check("t3_send_idx", send_idx_o, 0);
    send_ready_i = 1'b1;
    tick();
    send_ready_i = 1'b0;
    @(negedge clk_i);
    check("t3_sent_no_offer", send_valid_o, 0);
    check("t3_sent_not_empty", empty_o, 0);
    ack_i     = 1'b1;
    ack_idx_i = '0;
    tick();
    ack_i = 1'b0;
    @(negedge clk_i);
    check("t3_empty_after_ack", empty_o, 1);

    // Threshold 2: writes every cycle keep entry 0 open; closes 3 cycles after.
    cfg_thresh_i = TW'(2);
    do_reset();
    alloc_i = 1'b1;
    tick();
    alloc_i     = 1'b0;
    write_i     = 1'b1;
    write_idx_i = '0;
    repeat (10) tick();
    write_i = 1'b0;
    wait_valid(20, n);
    check("wr_pend_latency", n, 3);

    // Fill all entries, flush, send 0..15 in order, ack in reverse order.
    cfg_thresh_i = TW'(15);
    do_reset();
    alloc_i = 1'b1;
    repeat (N) tick();
    alloc_i = 1'b0;
    @(negedge clk_i);
    check("fill_full", full_o, 1);
    check("fill_alloc_ready", alloc_ready_o, 0);
    flush_all_i = 1'b1;
    tick();
    flush_all_i = 1'b0;
    collect_sends(N, 40);
    check("fill_send_count", sent_q.size(), N);
    for (int i = 0; i < sent_q.size(); i++) check("fill_send_order", sent_q[i], i);
    for (int i = N - 1; i >= 0; i--) ack_one(i);
    @(negedge clk_i);
    check("fill_empty_after_acks", empty_o, 1);
    check("fill_alloc_idx_after_acks", alloc_idx_o, 0);

    // Round-robin: build PEND {2,5,9} with the pointer at 6.
    do_reset();
    alloc_i = 1'b1;
    repeat (9) tick();             // entries 0..8 open
    alloc_i     = 1'b0;
    flush_all_i = 1'b1;
    tick();
    flush_all_i = 1'b0;
    collect_sends(9, 20);          // 0..8 sent, pointer 9
    check("rr_pre_sends", sent_q.size(), 9);
    ack_one(5);
    alloc_i = 1'b1;
    tick();                        // reopens 5
    alloc_i     = 1'b0;
    flush_all_i = 1'b1;
    tick();
    flush_all_i = 1'b0;
    collect_sends(1, 10);          // 5 sent, pointer 6
    check("rr_resend_5", sent_q.size() > 0 ? sent_q[0] : -1, 5);
    ack_one(2);
    ack_one(5);
    alloc_i = 1'b1;
    repeat (3) tick();             // opens 2,5,9
    alloc_i     = 1'b0;
    flush_all_i = 1'b1;
    tick();
    flush_all_i = 1'b0;
    @(negedge clk_i);
    check("rr_first_offer", send_idx_o, 9);
    collect_sends(3, 10);
    exp_rr = '{9, 2, 5};
    check("rr_send_count", sent_q.size(), 3);
    for (int i = 0; i < sent_q.size() && i < 3; i++) check("rr_send_order", sent_q[i], exp_rr[i]);

    // Reset with entries SENT, then write+flush on entry 1 and a stray ack.
    do_reset();
    alloc_i = 1'b1;
    repeat (2) tick();             // entries 0,1 open
    alloc_i     = 1'b0;
    write_i     = 1'b1;
    write_idx_i = IW'(1);
    flush_all_i = 1'b1;
    tick();
    write_i     = 1'b0;
    flush_all_i = 1'b0;
    ack_one(1);                    // entry 1 is PEND: ignored
    @(negedge clk_i);
    check("wf_not_empty", empty_o, 0);
    check("wf_offer_valid", send_valid_o, 1);
    collect_sends(2, 10);
    check("wf_send_count", sent_q.size(), 2);
    for (int i = 0; i < sent_q.size() && i < 2; i++) check("wf_send_order", sent_q[i], i);
    ack_one(0);
    ack_one(1);
    @(negedge clk_i);
    check("wf_empty", empty_o, 1);

    // Threshold 0: entry closes on the first edge after allocation.
    cfg_thresh_i = '0;
    do_reset();
    alloc_i = 1'b1;
    tick();
    alloc_i = 1'b0;
    wait_valid(10, n);
    check("t0_pend_latency", n, 1);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
